// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Unsigned core with sign fix-up, fast path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rem, dvd, dsr;
  logic [CNT_W-1:0] cnt;
  logic             is_rem, neg_q, neg_r;

  logic             accept, is_signed, div0, ovf, fast, last;
  logic [WIDTH-1:0] a_abs, b_abs, special;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_nxt, q_nxt, fix;

  assign accept    = (state == IDLE) && start && funct3[2] && !flush;
  assign is_signed = !funct3[0];
  assign div0      = (op_b == '0);
  assign ovf       = is_signed && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  assign fast      = div0 || ovf;
  assign a_abs     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_abs     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  // RISC-V mandated results that bypass the iteration
  assign special   = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  // One restoring step; the extra top bit of the trial is the borrow
  assign rem_sh  = {rem, dvd[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dsr};
  assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt   = {dvd[WIDTH-2:0], ~trial[WIDTH]};
  assign fix     = is_rem ? (neg_r ? -rem_nxt : rem_nxt) : (neg_q ? -q_nxt : q_nxt);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign stall = accept || (state == RUN);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      cnt    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
    end else if (accept) begin
      is_rem <= funct3[1];
      neg_q  <= is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r  <= is_signed && op_a[WIDTH-1];
      rem    <= '0;
      dvd    <= a_abs;
      dsr    <= b_abs;
      cnt    <= '0;
      if (fast) result <= special;
    end else if (state == RUN && !flush) begin
      rem <= rem_nxt;
      dvd <= q_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) result <= fix;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, multi-cycle corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0, op_b = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] t;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      sa = $signed(a);
      sb = $signed(b);
      t  = f[1] ? sa % sb : sa / sb;
    end else begin
      t = f[1] ? {32'd0, a} % {32'd0, b} : {32'd0, a} / {32'd0, b};
    end
    return t[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one op for a single cycle; reports result, latency in cycles from
  // the start cycle, stall in the start cycle, stall cycles after acceptance.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output logic stall0,
                       output int stall_n, output int dcyc);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1 stall0 = stall;
    stall_n = 0; dcyc = -1; r = 'x;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (lat <= 60) begin
      #1;
      if (done) begin
        r = result; dcyc = cyc;
        break;
      end
      if (stall) stall_n++;
      @(negedge clk);
      lat++;
    end
    if (dcyc < 0) begin
      tests++; fails++;
      $display("FAIL timeout waiting for done: got none expected within 60 cycles");
    end
  endtask

  task automatic wait_done(output logic [31:0] r);
    r = 'x;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (done) begin r = result; return; end
    end
    tests++; fails++;
    $display("FAIL timeout waiting for done: got none expected within 60 cycles");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, r2, a, b;
    logic [2:0]  f;
    logic        s0;
    int          lat, sn, d1, d2, ndone;

    vecs[0]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{F_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[3]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[4]  = '{F_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[5]  = '{F_DIV,  32'h1234,       32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{F_REMU, 32'h1234,       32'd0,          32'h1234,       1};
    vecs[7]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[8]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[9]  = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[10] = '{F_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[11] = '{F_DIV,  32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  33};

    // reset state
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // non-divide funct3 is ignored
    @(negedge clk); start = 1'b1; funct3 = 3'b010; op_a = 32'd9; op_b = 32'd3;
    #1 chk("non-div stall", {31'd0, stall}, 32'd0);
    @(negedge clk); start = 1'b0; #1 chk("non-div busy", {31'd0, busy}, 32'd0);

    // flush in the start cycle blocks acceptance
    @(negedge clk); start = 1'b1; funct3 = F_DIVU; flush = 1'b1;
    #1 chk("flush+start stall", {31'd0, stall}, 32'd0);
    @(negedge clk); start = 1'b0; flush = 1'b0; #1 chk("flush+start busy", {31'd0, busy}, 32'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat, s0, sn, d1);
      chk($sformatf("vec%0d result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d accept stall", i), {31'd0, s0}, 32'd1);
      chk($sformatf("vec%0d run stalls", i), sn, (vecs[i].lat == 33) ? 32 : 0);
    end

    // flush mid-RUN: no done, result held, then a fresh op completes
    @(negedge clk); start = 1'b1; funct3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    #1 chk("flush busy", {31'd0, busy}, 32'd0);
    ndone = 0;
    repeat (40) begin @(negedge clk); #1 if (done) ndone++; end
    chk("flush no done", ndone, 32'd0);
    chk("flush result held", result, vecs[11].exp);
    do_op(F_DIVU, 32'd1000, 32'd3, r, lat, s0, sn, d1);
    chk("after flush result", r, 32'd333);

    // start re-pulsed during RUN is ignored
    @(negedge clk); start = 1'b1; funct3 = F_DIV; op_a = -32'sd100; op_b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct3 = F_REMU; op_a = 32'd50; op_b = 32'd2;
    @(negedge clk); start = 1'b0;
    wait_done(r);
    chk("repulse result", r, 32'hFFFF_FFF2);
    @(negedge clk); @(negedge clk);
    #1 chk("repulse not queued", {31'd0, busy}, 32'd0);

    // back-to-back: second start in the cycle after done
    do_op(F_DIV, 32'd1000, 32'hFFFF_FFF6, r, lat, s0, sn, d1);
    do_op(F_REMU, 32'd1000, 32'd7, r2, lat, s0, sn, d2);
    chk("b2b first", r, 32'hFFFF_FF9C);
    chk("b2b second", r2, 32'd6);
    chk("b2b spacing", d2 - d1, 32'd34);

    // asynchronous reset mid-RUN
    @(negedge clk); start = 1'b1; funct3 = F_DIVU; op_a = 32'd77; op_b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst done", {31'd0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    chk("async rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      f = 3'(4 + $urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op(f, a, b, r, lat, s0, sn, d1);
      chk($sformatf("rand%0d f=%b a=%h b=%h", n, f, a, b), r, model(f, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
